// File: rtl/tis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tis_pkg
// Purpose  : Shared constants and the register-level opcode set of a
//            TIS-100-style execution node.
// Contents : WIDTH   - datapath width (11-bit two's complement)
//            ACC_MAX - saturation magnitude (+/-999)
//            op_e    - 2-bit operation select seen by the ACC/BAK pair
// Revision : 1.0 - initial release
// ============================================================================
package tis_pkg;

  localparam int WIDTH   = 11;
  localparam int ACC_MAX = 999;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_ADD   = 2'd1,
    OP_SAV   = 2'd2,
    OP_SWP   = 2'd3
  } op_e;

endpackage
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// ============================================================================
// Module   : sat_clamp
// Purpose  : Saturates a (WIDTH+1)-bit signed value into -ACC_MAX..+ACC_MAX
//            and narrows it to WIDTH bits. Purely combinational.
// Ports    : din_i  [WIDTH:0]   signed value to clamp (one guard bit)
//            dout_o [WIDTH-1:0] clamped result
// Revision : 1.0 - initial release
// ============================================================================
module sat_clamp #(
  parameter int WIDTH   = tis_pkg::WIDTH,
  parameter int ACC_MAX = tis_pkg::ACC_MAX
) (
  input  logic signed [WIDTH:0]   din_i,
  output logic signed [WIDTH-1:0] dout_o
);

  localparam int                  NEG_MAX   = -ACC_MAX;
  localparam logic signed [WIDTH:0] c_pos_max = ACC_MAX[WIDTH:0];
  localparam logic signed [WIDTH:0] c_neg_max = NEG_MAX[WIDTH:0];

  // Both limits fit in WIDTH bits, so dropping the guard bit is lossless
  // on every branch.
  always_comb begin
    if (din_i > c_pos_max) begin
      dout_o = c_pos_max[WIDTH-1:0];
    end else if (din_i < c_neg_max) begin
      dout_o = c_neg_max[WIDTH-1:0];
    end else begin
      dout_o = din_i[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/registers.sv
`default_nettype none
// ============================================================================
// Module   : registers
// Purpose  : ACC/BAK register pair of a TIS-100-style execution node.
//            Executes WRITE/ADD/SAV/SWP and presents ACC on 'out'.
// Ports    : clk       - system clock, rising-edge
//            reset     - asynchronous active-low clear of ACC and BAK
//            clk_en    - operation enable; state holds when low
//            instr     - operation select (tis_pkg::op_e encoding)
//            input_val - signed operand from the node datapath
//            out       - registered ACC value
// Revision : 1.0 - initial release
// ============================================================================
module registers #(
  parameter int WIDTH   = tis_pkg::WIDTH,
  parameter int ACC_MAX = tis_pkg::ACC_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic [1:0]              instr,
  input  logic signed [WIDTH-1:0] input_val,
  output logic signed [WIDTH-1:0] out
);

  import tis_pkg::*;

  op_e                     w_op;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] bak_q, bak_d;
  logic signed [WIDTH:0]   w_operand_ext;
  logic signed [WIDTH:0]   w_sum;
  logic signed [WIDTH:0]   w_clamp_in;
  logic signed [WIDTH-1:0] w_clamped;

  assign w_op = op_e'(instr);

  // One guard bit is enough: |ACC| <= 999 and |input_val| <= 1024 keep the
  // sum well inside 12-bit signed range.
  assign w_operand_ext = {input_val[WIDTH-1], input_val};
  assign w_sum         = {acc_q[WIDTH-1], acc_q} + w_operand_ext;

  // WRITE also goes through the clamp so out-of-range operands saturate.
  assign w_clamp_in = (w_op == OP_ADD) ? w_sum : w_operand_ext;

  sat_clamp #(
    .WIDTH   (WIDTH),
    .ACC_MAX (ACC_MAX)
  ) u_sat_clamp (
    .din_i  (w_clamp_in),
    .dout_o (w_clamped)
  );

  always_comb begin
    acc_d = acc_q;
    bak_d = bak_q;
    if (clk_en) begin
      case (w_op)
        OP_WRITE,
        OP_ADD:  acc_d = w_clamped;
        OP_SAV:  bak_d = acc_q;
        OP_SWP: begin
          acc_d = bak_q;
          bak_d = acc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      bak_q <= '0;
    end else begin
      acc_q <= acc_d;
      bak_q <= bak_d;
    end
  end

  assign out = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_registers.sv
`default_nettype none
// ============================================================================
// Module   : tb_registers
// Purpose  : Self-checking bench for the ACC/BAK register pair: directed
//            vector table, reset/async-clear sequences and a random run
//            against a behavioural ACC/BAK model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_registers;

  localparam logic [1:0] I_WRITE = 2'd0;
  localparam logic [1:0] I_ADD   = 2'd1;
  localparam logic [1:0] I_SAV   = 2'd2;
  localparam logic [1:0] I_SWP   = 2'd3;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_en;
  logic [1:0]         instr;
  logic signed [10:0] input_val;
  logic signed [10:0] out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state and scoreboard of expected 'out' values.
  int m_acc = 0;
  int m_bak = 0;
  int sb_q[$];

  typedef struct {
    logic       en;
    logic [1:0] op;
    int         val;
    int         exp_out;
  } vec_t;

  vec_t vecs[$];

  registers #(
    .WIDTH   (11),
    .ACC_MAX (999)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .instr     (instr),
    .input_val (input_val),
    .out       (out)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v > 999)  return 999;
    if (v < -999) return -999;
    return v;
  endfunction

  function automatic int sx11(input int v);
    logic signed [10:0] t;
    t = v[10:0];
    return int'(t);
  endfunction

  task automatic model_step(input logic en, input logic [1:0] op, input int val);
    int t;
    if (!en) return;
    case (op)
      I_WRITE: m_acc = clamp(sx11(val));
      I_ADD:   m_acc = clamp(m_acc + sx11(val));
      I_SAV:   m_bak = m_acc;
      default: begin
        t     = m_acc;
        m_acc = m_bak;
        m_bak = t;
      end
    endcase
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, let one rising edge pass,
  // then compare at the next falling edge against the scoreboard head.
  task automatic apply(input string name, input logic en, input logic [1:0] op,
                       input int val, input int exp_out, input bit use_exp);
    int e;
    clk_en    = en;
    instr     = op;
    input_val = val[10:0];
    model_step(en, op, val);
    sb_q.push_back(use_exp ? exp_out : m_acc);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, int'(out), e);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] op,
                              input int val, input int exp_out);
    vec_t v;
    v.en = en; v.op = op; v.val = val; v.exp_out = exp_out;
    return v;
  endfunction

  initial begin
    reset     = 1'b0;
    clk_en    = 1'b1;
    instr     = I_WRITE;
    input_val = 11'sd7;

    // Reset holds ACC at zero even with an enabled WRITE on the inputs.
    #1 check("reset_initial", int'(out), 0);
    @(posedge clk);
    @(negedge clk);
    check("reset_over_enable", int'(out), 0);
    reset = 1'b1;

    vecs.push_back(mk(1, I_WRITE,    5,    5));
    vecs.push_back(mk(1, I_ADD,      7,   12));
    vecs.push_back(mk(1, I_ADD,    -20,   -8));
    vecs.push_back(mk(1, I_WRITE,  990,  990));
    vecs.push_back(mk(1, I_ADD,     50,  999));
    vecs.push_back(mk(1, I_ADD,     -1,  998));
    vecs.push_back(mk(1, I_WRITE, -1000, -999));
    vecs.push_back(mk(1, I_ADD,   -999, -999));
    vecs.push_back(mk(1, I_WRITE, 1023,  999));
    vecs.push_back(mk(1, I_WRITE,   42,   42));
    vecs.push_back(mk(1, I_SAV,    555,   42));
    vecs.push_back(mk(1, I_WRITE,   -7,   -7));
    vecs.push_back(mk(1, I_SWP,    123,   42));
    vecs.push_back(mk(1, I_SWP,   -321,   -7));
    vecs.push_back(mk(1, I_WRITE,  100,  100));
    vecs.push_back(mk(0, I_ADD,      5,  100));
    vecs.push_back(mk(0, I_WRITE,    3,  100));
    vecs.push_back(mk(0, I_ADD,      5,  100));
    vecs.push_back(mk(1, I_ADD,      5,  105));
    // SAV immediately followed by SWP exchanges with the fresh BAK.
    vecs.push_back(mk(1, I_SAV,      0,  105));
    vecs.push_back(mk(1, I_WRITE,   -1,   -1));
    vecs.push_back(mk(1, I_SAV,      0,   -1));
    vecs.push_back(mk(1, I_SWP,      0,   -1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i].en, vecs[i].op, vecs[i].val,
            vecs[i].exp_out, 1'b1);
    end

    // Async clear between edges: ACC=300, BAK=200.
    apply("pre_bak",  1, I_WRITE, 200, 200, 1'b1);
    apply("pre_sav",  1, I_SAV,     0, 200, 1'b1);
    apply("pre_acc",  1, I_WRITE, 300, 300, 1'b1);
    clk_en = 1'b0;
    #1 reset = 1'b0;
    #1 check("async_clear", int'(out), 0);
    m_acc = 0;
    m_bak = 0;
    #1 reset = 1'b1;
    #1;
    apply("post_reset_swp", 1, I_SWP, 77, 0, 1'b1);
    apply("post_reset_add", 1, I_ADD, 10, 10, 1'b1);

    // Random run against the model.
    for (int n = 0; n < 10000; n++) begin
      apply("random", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 2047)), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
